axi_rd_xbar: RTL and testbench
==============================

// Module: axi_rd_xbar
// PURPOSE
//  Parametrised AXI read-path interconnect (AR + R) for NUM_M masters and NUM_S slaves.
//  Adds an internal DECERR default slave, round-robin arbitration and master-index ID extension.
//  Serves one outstanding burst at a time; sits between CPU/DMA read ports and memory slaves.
// PARAMETERS
//  NUM_M    2              number of masters (>=1)
//  NUM_S    2              number of external slaves (>=1)
//  ID_W     4              master-side ID width
//  ADDR_W   32             address width
//  DATA_W   32             data width
//  LEN_W    4              ARLEN width (bursts of 1..2**LEN_W beats)
//  SLV_BASE {NUM_S{ADDR_W}} packed base address per slave; slot s = [s*ADDR_W +: ADDR_W]
//  SLV_MASK {NUM_S{ADDR_W}} packed mask per slave; slave s hit iff (addr & mask_s) == base_s
//  MIDX_W   $clog2(NUM_M) or 1 if NUM_M==1; IDS_W = ID_W + MIDX_W (derived, not overridable)
// PORTS
//  clk       in   1              clock
//  rst       in   1              async reset, active-high
//  m_arid    in   NUM_M*ID_W     per-master AR fields, packed by master index;
//  m_araddr  in   NUM_M*ADDR_W     m_arlen/m_arsize/m_arburst have widths NUM_M*LEN_W / *3 / *2
//  m_arvalid in   NUM_M          per-master AR valid
//  m_arready out  NUM_M          per-master AR ready
//  m_rid     out  ID_W           shared R bus to all masters: rid, rdata(DATA_W), rresp(2), rlast(1)
//  m_rvalid  out  NUM_M          R valid, asserted only toward the owning master
//  m_rready  in   NUM_M          per-master R ready
//  s_arid    out  IDS_W          shared AR bus to slaves: {master idx, master ID}; araddr/arlen/arsize/arburst
//  s_arvalid out  NUM_S          per-slave AR valid
//  s_arready in   NUM_S          per-slave AR ready
//  s_rid     in   NUM_S*IDS_W    per-slave R fields: rid, rdata, rresp, rlast (packed by slave index)
//  s_rvalid  in   NUM_S          per-slave R valid
//  s_rready  out  NUM_S          per-slave R ready
// BEHAVIOUR
//  Reset: FSM=IDLE, rr pointer=0, latched AR regs=0; every out port 0 (s_arid etc. 0).
//  FSM IDLE: grant = first m_arvalid at/after rr pointer (round-robin); m_arready[grant]=1 same cycle
//   (combinational); on that cycle latch AR fields, owner=grant, decode target; rr pointer <= grant+1 mod NUM_M.
//   Decode: lowest-index slave hit wins; no hit -> target=DEFAULT. Next: ADDR if hit, else ERR.
//  ADDR: s_arvalid[target]=1 with latched fields, held stable until s_arready[target]; then -> DATA.
//   Latency: master AR accept at cycle N -> s_arvalid at N+1 minimum.
//  DATA: combinational R route: m_rvalid[owner]=s_rvalid[target], s_rready[target]=m_rready[owner];
//   m_rid=s_rid[target][ID_W-1:0] (index bits stripped). All other s_rready/m_rvalid =0.
//   On beat with rvalid&rready&rlast -> IDLE. Slave RLAST is authoritative (no beat count check).
//  ERR (default slave): emits ARLEN+1 beats, rdata=0, rresp=2'b11 DECERR, rid=latched ID,
//   rlast on final beat; beat counter LEN_W+1 bits advances only on m_rready[owner]; last -> IDLE.
//  No R data from non-target slaves is consumed; their s_rready stays 0.
//  Simultaneous requests: only grant accepted; others keep m_arvalid and are served later in rr order.
//  m_arvalid dropped before grant: no effect. ARLEN=max -> 2**LEN_W beats, counter must not wrap early.
//  Reset asserted mid-burst: immediate return to IDLE, all valids/readies deasserted asynchronously.
//  NUM_M==1: arbiter degenerates to fixed grant; MIDX bit in s_arid is 0.
// STRUCTURE
//  Package axi_rd_xbar_pkg: state enum {IDLE,ADDR,DATA,ERR}, RESP_OKAY/RESP_DECERR constants,
//   IDS_W/MIDX_W helper functions.
//  Sub-module rr_arbiter (NUM_M requests, grant one-hot + index, advance input); reused on AW path later.
//  Decode and R mux stay inline in the top module.
// TESTING
//  1 Single read: M0 araddr in S0 region, arlen=3 -> s_arvalid[0] at N+1, s_arid={0,id}, 4 beats to M0, m_rid=id.
//  2 Contention: M0,M1 both valid at reset exit -> M0 served first, then M1; next round starts at M0 again.
//  3 Unmapped addr 0xFFFF_0000 arlen=2 -> no s_arvalid, 3 beats rresp=2'b11 rdata=0, rlast on beat 3.
//  4 Backpressure: m_rready toggled 1/0 during S1 burst -> s_rready mirrors exactly, no beat lost/duplicated.
//  5 Stall: s_arready held 0 for 10 cycles -> s_arvalid and AR fields stable throughout, no m_arready.
//  6 Reset during DATA beat 2 of 8 -> next cycle all outputs 0, FSM IDLE; new read completes normally.

Source files
------------

// File: rtl/axi_rd_xbar_pkg.sv
// rtl/axi_rd_xbar_pkg.sv - shared types, response codes and width helpers for the AXI read crossbar
package axi_rd_xbar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int midx_w(input int num_m);
        return (num_m > 1) ? $clog2(num_m) : 1;
    endfunction

    function automatic int ids_w(input int id_w, input int num_m);
        return id_w + midx_w(num_m);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter: first request at/after pointer wins, pointer moves past winner on advance
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    input  logic             advance_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand_idx;

    // Scan downward so the last hit written is the closest request at/after the pointer.
    always_comb begin
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        cand_idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand_idx = IDX_W'((int'(ptr_q) + i) % N);
            if (req_i[cand_idx]) begin
                gnt_idx_o   = cand_idx;
                gnt_valid_o = 1'b1;
            end
        end
        gnt_o = '0;
        if (gnt_valid_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= IDX_W'((int'(gnt_idx_o) + 1) % N);
        end
    end

endmodule

// File: rtl/axi_rd_xbar.sv
// rtl/axi_rd_xbar.sv - single-outstanding AXI read crossbar with RR arbitration, decode, R routing and DECERR slave
module axi_rd_xbar
    import axi_rd_xbar_pkg::*;
#(
    parameter int NUM_M  = 2,
    parameter int NUM_S  = 2,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter logic [NUM_S*ADDR_W-1:0] SLV_BASE = {32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_S*ADDR_W-1:0] SLV_MASK = {32'hF000_0000, 32'hF000_0000},
    localparam int MIDX_W = midx_w(NUM_M),
    localparam int IDS_W  = ids_w(ID_W, NUM_M)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_M*ID_W-1:0]   m_arid,
    input  logic [NUM_M*ADDR_W-1:0] m_araddr,
    input  logic [NUM_M*LEN_W-1:0]  m_arlen,
    input  logic [NUM_M*3-1:0]      m_arsize,
    input  logic [NUM_M*2-1:0]      m_arburst,
    input  logic [NUM_M-1:0]        m_arvalid,
    output logic [NUM_M-1:0]        m_arready,
    output logic [ID_W-1:0]         m_rid,
    output logic [DATA_W-1:0]       m_rdata,
    output logic [1:0]              m_rresp,
    output logic                    m_rlast,
    output logic [NUM_M-1:0]        m_rvalid,
    input  logic [NUM_M-1:0]        m_rready,
    output logic [IDS_W-1:0]        s_arid,
    output logic [ADDR_W-1:0]       s_araddr,
    output logic [LEN_W-1:0]        s_arlen,
    output logic [2:0]              s_arsize,
    output logic [1:0]              s_arburst,
    output logic [NUM_S-1:0]        s_arvalid,
    input  logic [NUM_S-1:0]        s_arready,
    input  logic [NUM_S*IDS_W-1:0]  s_rid,
    input  logic [NUM_S*DATA_W-1:0] s_rdata,
    input  logic [NUM_S*2-1:0]      s_rresp,
    input  logic [NUM_S-1:0]        s_rlast,
    input  logic [NUM_S-1:0]        s_rvalid,
    output logic [NUM_S-1:0]        s_rready
);

    localparam int SIDX_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;
    localparam int TGT_W  = $clog2(NUM_S + 1);
    localparam logic [TGT_W-1:0] TGT_DEF = TGT_W'(NUM_S);

    state_e            state_q;
    logic [MIDX_W-1:0] owner_q;
    logic [TGT_W-1:0]  target_q;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [NUM_S-1:0]  arvalid_q;
    logic [LEN_W:0]    beat_q;

    logic [NUM_M-1:0]  gnt;
    logic [MIDX_W-1:0] gnt_idx;
    logic              gnt_valid;
    logic              idle;
    logic              accept;
    logic [ADDR_W-1:0] gnt_addr;
    logic [TGT_W-1:0]  dec_tgt;
    logic [SIDX_W-1:0] tsel;
    logic              err_last;

    assign idle     = (state_q == IDLE);
    assign accept   = idle & gnt_valid;
    assign gnt_addr = m_araddr[gnt_idx*ADDR_W +: ADDR_W];
    assign tsel     = target_q[SIDX_W-1:0];
    assign err_last = (beat_q == {1'b0, len_q});

    rr_arbiter #(
        .N     (NUM_M),
        .IDX_W (MIDX_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (m_arvalid),
        .advance_i   (accept),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // Lowest-index hit wins; no hit routes to the internal DECERR slave.
    always_comb begin
        dec_tgt = TGT_DEF;
        for (int s = NUM_S - 1; s >= 0; s--) begin
            if ((gnt_addr & SLV_MASK[s*ADDR_W +: ADDR_W]) == SLV_BASE[s*ADDR_W +: ADDR_W]) begin
                dec_tgt = TGT_W'(s);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            target_q  <= '0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            arvalid_q <= '0;
            beat_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (gnt_valid) begin
                    owner_q  <= gnt_idx;
                    target_q <= dec_tgt;
                    id_q     <= m_arid[gnt_idx*ID_W +: ID_W];
                    addr_q   <= gnt_addr;
                    len_q    <= m_arlen[gnt_idx*LEN_W +: LEN_W];
                    size_q   <= m_arsize[gnt_idx*3 +: 3];
                    burst_q  <= m_arburst[gnt_idx*2 +: 2];
                    beat_q   <= '0;
                    if (dec_tgt == TGT_DEF) begin
                        state_q <= ERR;
                    end else begin
                        state_q   <= ADDR;
                        arvalid_q <= NUM_S'(1) << dec_tgt;
                    end
                end
                ADDR: if (s_arready[tsel]) begin
                    arvalid_q <= '0;
                    state_q   <= DATA;
                end
                DATA: if (s_rvalid[tsel] && m_rready[owner_q] && s_rlast[tsel]) begin
                    state_q <= IDLE;
                end
                ERR: if (m_rready[owner_q]) begin
                    if (err_last) begin
                        state_q <= IDLE;
                        beat_q  <= '0;
                    end else begin
                        beat_q <= beat_q + (LEN_W+1)'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reset also blanks the combinational grant so no AR handshake can appear while held in reset.
    assign m_arready = (idle && !rst) ? gnt : '0;
    assign s_arvalid = arvalid_q;
    assign s_arid    = {owner_q, id_q};
    assign s_araddr  = addr_q;
    assign s_arlen   = len_q;
    assign s_arsize  = size_q;
    assign s_arburst = burst_q;

    always_comb begin
        m_rvalid = '0;
        s_rready = '0;
        m_rid    = '0;
        m_rdata  = '0;
        m_rresp  = RESP_OKAY;
        m_rlast  = 1'b0;
        if (state_q == DATA) begin
            m_rvalid[owner_q] = s_rvalid[tsel];
            s_rready[tsel]    = m_rready[owner_q];
            m_rid             = s_rid[tsel*IDS_W +: ID_W];
            m_rdata           = s_rdata[tsel*DATA_W +: DATA_W];
            m_rresp           = s_rresp[tsel*2 +: 2];
            m_rlast           = s_rlast[tsel];
        end else if (state_q == ERR) begin
            m_rvalid[owner_q] = 1'b1;
            m_rid             = id_q;
            m_rresp           = RESP_DECERR;
            m_rlast           = err_last;
        end
    end

endmodule

// File: tb/tb_axi_rd_xbar.sv
// tb/tb_axi_rd_xbar.sv - directed table-driven bench for axi_rd_xbar (2 masters, 2 slaves)
module tb_axi_rd_xbar;

    localparam int NM   = 2;
    localparam int NS   = 2;
    localparam int IDW  = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LW   = 4;
    localparam int IDSW = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [NM*IDW-1:0] m_arid;
    logic [NM*AW-1:0]  m_araddr;
    logic [NM*LW-1:0]  m_arlen;
    logic [NM*3-1:0]   m_arsize;
    logic [NM*2-1:0]   m_arburst;
    logic [NM-1:0]     m_arvalid;
    logic [NM-1:0]     m_arready;
    logic [IDW-1:0]    m_rid;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;
    logic [NM-1:0]     m_rvalid;
    logic [NM-1:0]     m_rready;
    logic [IDSW-1:0]   s_arid;
    logic [AW-1:0]     s_araddr;
    logic [LW-1:0]     s_arlen;
    logic [2:0]        s_arsize;
    logic [1:0]        s_arburst;
    logic [NS-1:0]     s_arvalid;
    logic [NS-1:0]     s_arready;
    logic [NS*IDSW-1:0] s_rid;
    logic [NS*DW-1:0]  s_rdata;
    logic [NS*2-1:0]   s_rresp;
    logic [NS-1:0]     s_rlast;
    logic [NS-1:0]     s_rvalid;
    logic [NS-1:0]     s_rready;

    axi_rd_xbar dut (
        .clk       (clk),
        .rst       (rst),
        .m_arid    (m_arid),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_arburst (m_arburst),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rid     (m_rid),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .s_arid    (s_arid),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),
        .s_arburst (s_arburst),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rid     (s_rid),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         m;
        logic [3:0] id;
        logic [31:0] addr;
        logic [3:0] len;
        int         stall;
        bit         bp;
        int         tgt;
        logic [4:0] arid;
        logic [1:0] resp;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_ar(input vec_t v);
        m_arvalid[v.m]              = 1'b1;
        m_arid[v.m*IDW +: IDW]      = v.id;
        m_araddr[v.m*AW +: AW]      = v.addr;
        m_arlen[v.m*LW +: LW]       = v.len;
        m_arsize[v.m*3 +: 3]        = 3'b010;
        m_arburst[v.m*2 +: 2]       = 2'b01;
        #1;
        chk("ar_grant", m_arready, 64'(1 << v.m));
        chk("s_arvalid_same_cycle", s_arvalid, 0);
        tick();
        m_arvalid[v.m] = 1'b0;
        #1;
        if (v.tgt < NS) begin
            chk("s_arvalid_n1", s_arvalid, 64'(1 << v.tgt));
            chk("s_arid", s_arid, v.arid);
            chk("s_araddr", s_araddr, v.addr);
            chk("s_arlen", s_arlen, v.len);
            chk("s_arsize", s_arsize, 3'b010);
            for (int c = 0; c < v.stall; c++) begin
                tick();
                #1;
                chk("stall_arvalid", s_arvalid, 64'(1 << v.tgt));
                chk("stall_araddr", s_araddr, v.addr);
                chk("stall_arid", s_arid, v.arid);
                chk("stall_arready", m_arready, 0);
            end
            s_arready[v.tgt] = 1'b1;
            tick();
            s_arready = '0;
            #1;
            chk("s_arvalid_drop", s_arvalid, 0);
        end else begin
            chk("err_no_arvalid", s_arvalid, 0);
        end
    endtask

    task automatic do_r(input vec_t v);
        int k;
        int cyc;
        logic rdy;
        logic [31:0] ed;
        k   = 0;
        cyc = 0;
        while (k <= int'(v.len) && cyc < 200) begin
            rdy = v.bp ? ~cyc[0] : 1'b1;
            m_rready       = '0;
            m_rready[v.m]  = rdy;
            ed = (v.tgt < NS) ? (32'hA500_0000 | 32'(k << 4) | 32'(v.m)) : 32'h0;
            s_rvalid = '0;
            s_rlast  = '0;
            if (v.tgt < NS) begin
                s_rvalid[v.tgt]             = 1'b1;
                s_rlast[v.tgt]              = (k == int'(v.len));
                s_rdata[v.tgt*DW +: DW]     = ed;
                s_rid[v.tgt*IDSW +: IDSW]   = v.arid;
                s_rresp[v.tgt*2 +: 2]       = 2'b00;
            end
            #1;
            chk("m_rvalid", m_rvalid, 64'(1 << v.m));
            chk("m_rdata", m_rdata, ed);
            chk("m_rid", m_rid, v.id);
            chk("m_rresp", m_rresp, v.resp);
            chk("m_rlast", m_rlast, (k == int'(v.len)));
            chk("s_rready", s_rready, (v.tgt < NS) ? 64'(rdy) << v.tgt : 64'(0));
            chk("ar_blocked", m_arready, 0);
            if (rdy) k++;
            cyc++;
            tick();
        end
        chk("r_done_in_budget", (cyc < 200), 1);
        m_rready = '0;
        s_rvalid = '0;
        s_rlast  = '0;
    endtask

    vec_t vt[7];
    vec_t c0, c1, v6;

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before timeout");
        $fatal(1);
    end

    initial begin
        c0 = '{0, 4'h1, 32'h0000_0010, 4'd0, 0, 1'b0, 0, 5'h01, 2'b00};
        c1 = '{1, 4'h2, 32'h1000_0020, 4'd1, 0, 1'b0, 1, 5'h12, 2'b00};
        v6 = '{0, 4'h4, 32'h0000_2000, 4'd7, 0, 1'b0, 0, 5'h04, 2'b00};
        vt[0] = '{0, 4'h5, 32'h0000_0100, 4'd3,  0,  1'b0, 0, 5'h05, 2'b00};
        vt[1] = '{1, 4'hA, 32'h1000_0040, 4'd3,  0,  1'b1, 1, 5'h1A, 2'b00};
        vt[2] = '{0, 4'h3, 32'hFFFF_0000, 4'd2,  0,  1'b0, 2, 5'h00, 2'b11};
        vt[3] = '{1, 4'h7, 32'h1234_5678, 4'd0,  10, 1'b0, 1, 5'h17, 2'b00};
        vt[4] = '{0, 4'hF, 32'h0FFF_FFFC, 4'd15, 0,  1'b0, 0, 5'h0F, 2'b00};
        vt[5] = '{1, 4'h2, 32'h8000_0000, 4'd15, 0,  1'b1, 2, 5'h00, 2'b11};
        vt[6] = '{0, 4'h9, 32'h2000_0000, 4'd1,  0,  1'b0, 2, 5'h00, 2'b11};

        rst = 1'b1;
        m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
        m_rready = '0; s_arready = '0; s_rid = '0; s_rdata = '0; s_rresp = '0;
        s_rlast = '0; s_rvalid = '0;
        m_arvalid = 2'b11;
        m_araddr[0 +: AW]  = c0.addr;
        m_araddr[AW +: AW] = c1.addr;
        tick();
        tick();
        #1;
        chk("rst_arready", m_arready, 0);
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_s_arid", s_arid, 0);
        chk("rst_s_araddr", s_araddr, 0);
        chk("rst_s_arlen", s_arlen, 0);
        chk("rst_m_rvalid", m_rvalid, 0);
        chk("rst_s_rready", s_rready, 0);
        chk("rst_m_rdata", m_rdata, 0);
        rst = 1'b0;

        do_ar(c0); do_r(c0);
        do_ar(c1); do_r(c1);
        m_arvalid = 2'b11;
        do_ar(c0); do_r(c0);
        do_ar(c1); do_r(c1);

        for (int i = 0; i < 7; i++) begin
            do_ar(vt[i]);
            do_r(vt[i]);
        end

        do_ar(v6);
        for (int k = 0; k < 3; k++) begin
            m_rready             = 2'b01;
            s_rvalid             = 2'b01;
            s_rlast              = '0;
            s_rdata[0 +: DW]     = 32'hBEEF_0000 + 32'(k);
            s_rid[0 +: IDSW]     = v6.arid;
            if (k < 2) tick();
        end
        #1;
        chk("mid_burst_rvalid", m_rvalid, 2'b01);
        chk("mid_burst_rdata", m_rdata, 32'hBEEF_0002);
        rst = 1'b1;
        #1;
        chk("rst_async_rvalid", m_rvalid, 0);
        chk("rst_async_srready", s_rready, 0);
        chk("rst_async_arvalid", s_arvalid, 0);
        chk("rst_async_arid", s_arid, 0);
        chk("rst_async_araddr", s_araddr, 0);
        chk("rst_async_rdata", m_rdata, 0);
        chk("rst_async_rlast", m_rlast, 0);
        tick();
        rst = 1'b0;
        m_rready = '0;
        s_rvalid = '0;
        s_rlast  = '0;
        do_ar(vt[0]);
        do_r(vt[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
